mc_ctrl: RTL and testbench
==========================

MC_CTRL -- requirements
Module: mc_ctrl

Interface
REQ-001 Parameter MEM_TIMEOUT, default 16, SHALL set the maximum cycles spent waiting for MIO_ready in one memory state (range 1..255).
REQ-002 Parameter EXC_VECTOR_SEL, default 2'b11, SHALL be the PCSource value driven in the exception state.
REQ-003 Ports SHALL be:
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-high reset.
- zero, overflow  in  1 each  ALU flags.
- MIO_ready  in  1  memory/IO ready.
- Inst_in  in  32  IR contents.
- MemRead, MemWrite, CPU_MIO, IorD, IRWrite, RegWrite, ALUSrcA, PCWrite, PCWriteCond, Branch  out  1 each  datapath strobes/selects.
- RegDst, MemtoReg, ALUSrcB, PCSource  out  2 each  mux selects.
- ALU_operation  out  3  ALU op.
- state_out  out  5  current state code.
- mem_fault  out  1  sticky memory-timeout flag.

Function
REQ-004 The block SHALL be a Moore FSM with states, by code: IF=0, ID=1, MADR=2, MRD=3, LWB=4, MWR=5, REXE=6, RWB=7, BR=8, J=9, IEXE=10, IWB=11, JAL=12, JR=13, EXC=14, HALT=15; state_out SHALL equal the current code.
REQ-005 All outputs SHALL be registered functions of the state only, with no combinational path from Inst_in or the flags.
REQ-006 IF: MemRead=1, IorD=0, CPU_MIO=1, ALUSrcA=0, ALUSrcB=01, ALU_operation=010, PCSource=00. IRWrite and PCWrite SHALL pulse for exactly one cycle, in the cycle MIO_ready=1; otherwise the FSM stays in IF.
REQ-007 ID: ALUSrcB=11 and ALU_operation=010. Next state by opcode: lw/sw→MADR, R-type→REXE (funct 001000 jr→JR), beq/bne→BR, j→J, jal→JAL, addi/andi/ori/xori/slti/lui→IEXE; any other opcode→EXC.
REQ-008 MADR→MRD (lw) or MWR (sw). MRD/MWR SHALL hold MemRead or MemWrite with IorD=1 until MIO_ready=1, then go to LWB or IF respectively.
REQ-009 A per-state wait counter SHALL clear on state entry; if it reaches MEM_TIMEOUT without MIO_ready (IF, MRD or MWR), mem_fault SHALL set and the FSM SHALL go to HALT.
REQ-010 ALU_operation encodings: and 000, or 001, add 010, xor 011, nor 100, srl 101, sub 110, slt 111; REXE SHALL decode funct, IEXE SHALL decode opcode, and lui SHALL use MemtoReg=11.
REQ-011 Write-back: RWB uses RegDst=01/MemtoReg=00, IWB 00/00 (lui 00/11), LWB 00/01, JAL 10/10. Each asserts RegWrite for one cycle and then goes to IF.
REQ-012 BR: ALU_operation=110, PCWriteCond=1, PCSource=01, Branch=1 for beq and 0 for bne (datapath qualifies with zero).
REQ-013 J: PCWrite=1, PCSource=10. JAL: as J plus link write. JR: PCWrite=1, PCSource=11 (when CTRL_EXC_EN is undefined).
REQ-014 HALT SHALL be absorbing until reset, with all strobes 0.
REQ-015 MemRead and MemWrite SHALL never be asserted in the same cycle.

Reset
REQ-016 While reset=1, state SHALL be IF, all 1-bit outputs and mux selects SHALL be 0, mem_fault=0 and the wait counter=0.
REQ-017 Reset asserted mid-instruction SHALL abort immediately; the first post-reset cycle SHALL be IF.

Configuration
REQ-018 Macro MC_CTRL_EXC_EN: when defined, overflow=1 in REXE/IEXE (add/addi/sub) SHALL suppress the following RegWrite, go to EXC, drive PCWrite=1 with PCSource=EXC_VECTOR_SEL for one cycle, then go to IF. The illegal-opcode path behaves the same. JR SHALL use PCSource=11 only if EXC_VECTOR_SEL differs from it (the datapath distinguishes them).
REQ-019 When MC_CTRL_EXC_EN is undefined, overflow SHALL be ignored, and an illegal opcode SHALL go to HALT instead of EXC.

Structure
REQ-020 Package mc_ctrl_pkg SHALL hold the state codes, opcode/funct constants, ALU_operation encodings and mux-select constants.
REQ-021 Sub-module mc_alu_dec (combinational funct/opcode→ALU_operation) SHALL be instantiated once.

Verification
REQ-022 add $3,$1,$2 with MIO_ready tied 1 → states 0,1,6,7,0, one RegWrite pulse with RegDst=01.
REQ-023 lw with MIO_ready held 0 for 3 cycles in MRD → MRD occupies 4 cycles and MemRead stays 1 throughout.
REQ-024 MIO_ready never rises in IF, MEM_TIMEOUT=4 → after 4 cycles mem_fault=1 and state_out=15 until reset.
REQ-025 With the macro defined, addi with overflow=1 → no RegWrite, EXC for 1 cycle with PCSource=11, then IF; with it undefined → IWB with RegWrite=1.
REQ-026 jal → states 0,1,12, RegDst=10, MemtoReg=10, PCSource=10, PCWrite=1.
REQ-027 reset pulsed during MWR → MemWrite drops asynchronously and state_out=0 on the next cycle.

Source files
------------

// File: rtl/mc_ctrl_pkg.sv
// Shared encodings for the multi-cycle controller: state codes, MIPS opcode/funct
// values, ALU operation codes, mux selects and the registered control bundle.
package mc_ctrl_pkg;

    typedef enum logic [4:0] {
        S_IF   = 5'd0,
        S_ID   = 5'd1,
        S_MADR = 5'd2,
        S_MRD  = 5'd3,
        S_LWB  = 5'd4,
        S_MWR  = 5'd5,
        S_REXE = 5'd6,
        S_RWB  = 5'd7,
        S_BR   = 5'd8,
        S_J    = 5'd9,
        S_IEXE = 5'd10,
        S_IWB  = 5'd11,
        S_JAL  = 5'd12,
        S_JR   = 5'd13,
        S_EXC  = 5'd14,
        S_HALT = 5'd15
    } state_e;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_JAL   = 6'b000011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_SLTI  = 6'b001010;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_XORI  = 6'b001110;
    localparam logic [5:0] OP_LUI   = 6'b001111;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;

    localparam logic [5:0] FN_SRL = 6'b000010;
    localparam logic [5:0] FN_JR  = 6'b001000;
    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;
    localparam logic [5:0] FN_XOR = 6'b100110;
    localparam logic [5:0] FN_NOR = 6'b100111;
    localparam logic [5:0] FN_SLT = 6'b101010;

    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_XOR = 3'b011;
    localparam logic [2:0] ALU_NOR = 3'b100;
    localparam logic [2:0] ALU_SRL = 3'b101;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_SLT = 3'b111;

    localparam logic [1:0] RD_RT = 2'b00;
    localparam logic [1:0] RD_RD = 2'b01;
    localparam logic [1:0] RD_RA = 2'b10;

    localparam logic [1:0] M2R_ALU = 2'b00;
    localparam logic [1:0] M2R_MEM = 2'b01;
    localparam logic [1:0] M2R_PC  = 2'b10;
    localparam logic [1:0] M2R_LUI = 2'b11;

    localparam logic [1:0] SRCB_REG  = 2'b00;
    localparam logic [1:0] SRCB_FOUR = 2'b01;
    localparam logic [1:0] SRCB_IMM  = 2'b10;
    localparam logic [1:0] SRCB_BOFS = 2'b11;

    localparam logic [1:0] PCS_ALU = 2'b00;
    localparam logic [1:0] PCS_BR  = 2'b01;
    localparam logic [1:0] PCS_JMP = 2'b10;
    localparam logic [1:0] PCS_JR  = 2'b11;

    // fetch marks IF; IRWrite and the fetch PC update are fetch gated by MIO_ready
    typedef struct packed {
        logic       mem_read;
        logic       mem_write;
        logic       cpu_mio;
        logic       iord;
        logic       fetch;
        logic       reg_write;
        logic       alu_src_a;
        logic       pc_write;
        logic       pc_write_cond;
        logic       branch;
        logic [1:0] reg_dst;
        logic [1:0] mem_to_reg;
        logic [1:0] alu_src_b;
        logic [1:0] pc_source;
        logic [2:0] alu_op;
    } ctrl_t;

endpackage

// File: rtl/mc_alu_dec.sv
// ALU operation decoder: R-type instructions decode funct, all others decode opcode.
module mc_alu_dec
    import mc_ctrl_pkg::*;
(
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    output logic [2:0] alu_op
);

    always_comb begin
        alu_op = ALU_ADD;
        if (opcode == OP_RTYPE) begin
            case (funct)
                FN_ADD:  alu_op = ALU_ADD;
                FN_SUB:  alu_op = ALU_SUB;
                FN_AND:  alu_op = ALU_AND;
                FN_OR:   alu_op = ALU_OR;
                FN_XOR:  alu_op = ALU_XOR;
                FN_NOR:  alu_op = ALU_NOR;
                FN_SLT:  alu_op = ALU_SLT;
                FN_SRL:  alu_op = ALU_SRL;
                default: alu_op = ALU_ADD;
            endcase
        end else begin
            case (opcode)
                OP_ANDI: alu_op = ALU_AND;
                OP_ORI:  alu_op = ALU_OR;
                OP_XORI: alu_op = ALU_XOR;
                OP_SLTI: alu_op = ALU_SLT;
                default: alu_op = ALU_ADD;
            endcase
        end
    end

endmodule

// File: rtl/mc_ctrl.sv
// Multi-cycle MIPS control FSM with registered, state-derived outputs and memory timeout.
// Define MC_CTRL_EXC_EN to trap overflow and illegal opcodes into the exception state.
module mc_ctrl
    import mc_ctrl_pkg::*;
#(
    parameter int         MEM_TIMEOUT    = 16,
    parameter logic [1:0] EXC_VECTOR_SEL = 2'b11
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        zero,
    input  logic        overflow,
    input  logic        MIO_ready,
    input  logic [31:0] Inst_in,
    output logic        MemRead,
    output logic        MemWrite,
    output logic        CPU_MIO,
    output logic        IorD,
    output logic        IRWrite,
    output logic        RegWrite,
    output logic        ALUSrcA,
    output logic        PCWrite,
    output logic        PCWriteCond,
    output logic        Branch,
    output logic [1:0]  RegDst,
    output logic [1:0]  MemtoReg,
    output logic [1:0]  ALUSrcB,
    output logic [1:0]  PCSource,
    output logic [2:0]  ALU_operation,
    output logic [4:0]  state_out,
    output logic        mem_fault
);

`ifdef MC_CTRL_EXC_EN
    localparam state_e     ILLEGAL_NEXT = S_EXC;
    // The datapath tells JR from the exception vector only when their selects differ
    localparam logic [1:0] JR_SEL = (EXC_VECTOR_SEL != PCS_JR) ? PCS_JR : PCS_ALU;
`else
    localparam state_e     ILLEGAL_NEXT = S_HALT;
    localparam logic [1:0] JR_SEL = PCS_JR;
`endif

    state_e     state_q, state_d;
    ctrl_t      ctrl_q, ctrl_d;
    logic [7:0] wait_q, wait_d;
    logic       mem_fault_q, mem_fault_d;
    logic [5:0] opcode, funct;
    logic [2:0] dec_alu_op;
    logic       mem_wait, timeout, ovf_trap;
    logic       unused_inputs;

    assign opcode = Inst_in[31:26];
    assign funct  = Inst_in[5:0];

    mc_alu_dec u_alu_dec (
        .opcode (opcode),
        .funct  (funct),
        .alu_op (dec_alu_op)
    );

`ifdef MC_CTRL_EXC_EN
    assign ovf_trap = overflow &&
        ((opcode == OP_RTYPE && (funct == FN_ADD || funct == FN_SUB)) || opcode == OP_ADDI);
    assign unused_inputs = ^{zero, Inst_in[25:6]};
`else
    assign ovf_trap = 1'b0;
    assign unused_inputs = ^{zero, overflow, Inst_in[25:6]};
`endif

    function automatic ctrl_t ctrl_for(input state_e s, input logic [5:0] op,
                                       input logic [2:0] dec_op);
        ctrl_t c;
        c = '0;
        case (s)
            S_IF: begin
                c.mem_read  = 1'b1;
                c.cpu_mio   = 1'b1;
                c.fetch     = 1'b1;
                c.alu_src_b = SRCB_FOUR;
                c.alu_op    = ALU_ADD;
                c.pc_source = PCS_ALU;
            end
            S_ID: begin
                c.alu_src_b = SRCB_BOFS;
                c.alu_op    = ALU_ADD;
            end
            S_MADR: begin
                c.alu_src_a = 1'b1;
                c.alu_src_b = SRCB_IMM;
                c.alu_op    = ALU_ADD;
            end
            S_MRD: begin
                c.mem_read = 1'b1;
                c.iord     = 1'b1;
                c.cpu_mio  = 1'b1;
            end
            S_MWR: begin
                c.mem_write = 1'b1;
                c.iord      = 1'b1;
                c.cpu_mio   = 1'b1;
            end
            S_LWB: begin
                c.reg_write  = 1'b1;
                c.reg_dst    = RD_RT;
                c.mem_to_reg = M2R_MEM;
            end
            S_REXE: begin
                c.alu_src_a = 1'b1;
                c.alu_src_b = SRCB_REG;
                c.alu_op    = dec_op;
            end
            S_RWB: begin
                c.reg_write  = 1'b1;
                c.reg_dst    = RD_RD;
                c.mem_to_reg = M2R_ALU;
            end
            S_IEXE: begin
                c.alu_src_a = 1'b1;
                c.alu_src_b = SRCB_IMM;
                c.alu_op    = dec_op;
            end
            S_IWB: begin
                c.reg_write  = 1'b1;
                c.reg_dst    = RD_RT;
                c.mem_to_reg = (op == OP_LUI) ? M2R_LUI : M2R_ALU;
            end
            S_BR: begin
                c.alu_src_a     = 1'b1;
                c.alu_src_b     = SRCB_REG;
                c.alu_op        = ALU_SUB;
                c.pc_write_cond = 1'b1;
                c.pc_source     = PCS_BR;
                c.branch        = (op == OP_BEQ);
            end
            S_J: begin
                c.pc_write  = 1'b1;
                c.pc_source = PCS_JMP;
            end
            S_JAL: begin
                c.pc_write   = 1'b1;
                c.pc_source  = PCS_JMP;
                c.reg_write  = 1'b1;
                c.reg_dst    = RD_RA;
                c.mem_to_reg = M2R_PC;
            end
            S_JR: begin
                c.alu_src_a = 1'b1;
                c.pc_write  = 1'b1;
                c.pc_source = JR_SEL;
            end
            S_EXC: begin
                c.pc_write  = 1'b1;
                c.pc_source = EXC_VECTOR_SEL;
            end
            default: c = '0;
        endcase
        return c;
    endfunction

    always_comb begin
        // Wait counting only runs while a memory strobe is actually up, so the
        // quiet first cycle after reset does not eat into the fetch budget.
        mem_wait = (state_q inside {S_IF, S_MRD, S_MWR}) &&
                   (ctrl_q.mem_read || ctrl_q.mem_write) && !MIO_ready;
        timeout  = mem_wait && (wait_q == 8'(MEM_TIMEOUT - 1));
        state_d     = state_q;
        mem_fault_d = mem_fault_q;
        case (state_q)
            S_IF:   if (ctrl_q.fetch && MIO_ready) state_d = S_ID;
            S_ID: begin
                case (opcode)
                    OP_LW, OP_SW:   state_d = S_MADR;
                    OP_RTYPE:       state_d = (funct == FN_JR) ? S_JR : S_REXE;
                    OP_BEQ, OP_BNE: state_d = S_BR;
                    OP_J:           state_d = S_J;
                    OP_JAL:         state_d = S_JAL;
                    OP_ADDI, OP_ANDI, OP_ORI, OP_XORI, OP_SLTI, OP_LUI:
                                    state_d = S_IEXE;
                    default:        state_d = ILLEGAL_NEXT;
                endcase
            end
            S_MADR: state_d = (opcode == OP_LW) ? S_MRD : S_MWR;
            S_MRD:  if (MIO_ready) state_d = S_LWB;
            S_MWR:  if (MIO_ready) state_d = S_IF;
            S_REXE: state_d = ovf_trap ? S_EXC : S_RWB;
            S_IEXE: state_d = ovf_trap ? S_EXC : S_IWB;
            S_LWB, S_RWB, S_IWB, S_BR, S_J, S_JAL, S_JR, S_EXC:
                    state_d = S_IF;
            default: state_d = S_HALT;
        endcase
        if (timeout) begin
            state_d     = S_HALT;
            mem_fault_d = 1'b1;
        end
        if (state_d != state_q) wait_d = 8'd0;
        else if (mem_wait)      wait_d = wait_q + 8'd1;
        else                    wait_d = wait_q;
        ctrl_d = ctrl_for(state_d, opcode, dec_alu_op);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= S_IF;
            ctrl_q      <= '0;
            wait_q      <= 8'd0;
            mem_fault_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            ctrl_q      <= ctrl_d;
            wait_q      <= wait_d;
            mem_fault_q <= mem_fault_d;
        end
    end

    assign MemRead       = ctrl_q.mem_read;
    assign MemWrite      = ctrl_q.mem_write;
    assign CPU_MIO       = ctrl_q.cpu_mio;
    assign IorD          = ctrl_q.iord;
    assign IRWrite       = ctrl_q.fetch & MIO_ready;
    assign RegWrite      = ctrl_q.reg_write;
    assign ALUSrcA       = ctrl_q.alu_src_a;
    assign PCWrite       = ctrl_q.pc_write | (ctrl_q.fetch & MIO_ready);
    assign PCWriteCond   = ctrl_q.pc_write_cond;
    assign Branch        = ctrl_q.branch;
    assign RegDst        = ctrl_q.reg_dst;
    assign MemtoReg      = ctrl_q.mem_to_reg;
    assign ALUSrcB       = ctrl_q.alu_src_b;
    assign PCSource      = ctrl_q.pc_source;
    assign ALU_operation = ctrl_q.alu_op;
    assign state_out     = state_q;
    assign mem_fault     = mem_fault_q;

endmodule

// File: tb/tb_mc_ctrl.sv
// Scoreboard bench for mc_ctrl: per-cycle expectations are queued by the stimulus
// and popped and compared by an independent negedge monitor.
module tb_mc_ctrl;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        zero = 1'b0;
    logic        overflow = 1'b0;
    logic        MIO_ready = 1'b0;
    logic [31:0] Inst_in = 32'd0;
    logic        MemRead, MemWrite, CPU_MIO, IorD, IRWrite, RegWrite, ALUSrcA;
    logic        PCWrite, PCWriteCond, Branch, mem_fault;
    logic [1:0]  RegDst, MemtoReg, ALUSrcB, PCSource;
    logic [2:0]  ALU_operation;
    logic [4:0]  state_out;

    mc_ctrl #(.MEM_TIMEOUT(4), .EXC_VECTOR_SEL(2'b11)) dut (
        .clk(clk), .reset(reset), .zero(zero), .overflow(overflow),
        .MIO_ready(MIO_ready), .Inst_in(Inst_in),
        .MemRead(MemRead), .MemWrite(MemWrite), .CPU_MIO(CPU_MIO), .IorD(IorD),
        .IRWrite(IRWrite), .RegWrite(RegWrite), .ALUSrcA(ALUSrcA),
        .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .Branch(Branch),
        .RegDst(RegDst), .MemtoReg(MemtoReg), .ALUSrcB(ALUSrcB),
        .PCSource(PCSource), .ALU_operation(ALU_operation),
        .state_out(state_out), .mem_fault(mem_fault)
    );

    always #5 clk = ~clk;

    typedef struct {
        string      tag;
        logic [4:0] st;
        logic [4:0] strb;   // {MemRead, MemWrite, RegWrite, PCWrite, IRWrite}
        logic [1:0] rd;
        logic [1:0] m2r;
        logic [1:0] pcs;
        logic [2:0] alu;
        logic       flt;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    localparam logic [31:0] I_ADD  = 32'h0022_1820;
    localparam logic [31:0] I_SLT  = 32'h0022_182A;
    localparam logic [31:0] I_LW   = 32'h8C22_0000;
    localparam logic [31:0] I_SW   = 32'hAC22_0004;
    localparam logic [31:0] I_ORI  = 32'h3422_0001;
    localparam logic [31:0] I_LUI  = 32'h3C02_0005;
    localparam logic [31:0] I_ADDI = 32'h2022_0001;
    localparam logic [31:0] I_JAL  = 32'h0C00_0010;
    localparam logic [31:0] I_BEQ  = 32'h1022_0003;
    localparam logic [31:0] I_BAD  = 32'hFC00_0000;

    function automatic exp_t E(string tag, logic [4:0] st, logic [4:0] strb, logic [1:0] rd,
                               logic [1:0] m2r, logic [1:0] pcs, logic [2:0] alu, logic flt);
        exp_t e;
        e.tag = tag; e.st = st; e.strb = strb; e.rd = rd;
        e.m2r = m2r; e.pcs = pcs; e.alu = alu; e.flt = flt;
        return e;
    endfunction

    task automatic cyc(input logic rst_v, input logic rdy, input logic [31:0] inst,
                       input logic ovf, input exp_t e);
        @(posedge clk);
        #1;
        reset = rst_v;
        MIO_ready = rdy;
        Inst_in = inst;
        overflow = ovf;
        sb.push_back(e);
    endtask

    task automatic do_reset();
        cyc(1'b1, 1'b0, 32'd0, 1'b0, E("reset", 5'd0, 5'b00000, 2'b00, 2'b00, 2'b00, 3'b000, 1'b0));
        cyc(1'b1, 1'b1, 32'd0, 1'b0, E("reset", 5'd0, 5'b00000, 2'b00, 2'b00, 2'b00, 3'b000, 1'b0));
        cyc(1'b0, 1'b0, 32'd0, 1'b0, E("post_reset", 5'd0, 5'b00000, 2'b00, 2'b00, 2'b00, 3'b000, 1'b0));
    endtask

    task automatic fetch_decode(input logic [31:0] inst, input logic ovf);
        cyc(1'b0, 1'b1, inst, ovf, E("if", 5'd0, 5'b10011, 2'b00, 2'b00, 2'b00, 3'b010, 1'b0));
        cyc(1'b0, 1'b1, inst, ovf, E("id", 5'd1, 5'b00000, 2'b00, 2'b00, 2'b00, 3'b010, 1'b0));
    endtask

    task automatic fetch_next(input logic [31:0] inst);
        cyc(1'b0, 1'b1, inst, 1'b0, E("if_next", 5'd0, 5'b10011, 2'b00, 2'b00, 2'b00, 3'b010, 1'b0));
    endtask

    initial begin : monitor
        exp_t e;
        logic [4:0] a_strb;
        forever begin
            @(negedge clk);
            if (sb.size() != 0) begin
                e = sb.pop_front();
                a_strb = {MemRead, MemWrite, RegWrite, PCWrite, IRWrite};
                checks++;
                if (state_out !== e.st || a_strb !== e.strb || RegDst !== e.rd ||
                    MemtoReg !== e.m2r || PCSource !== e.pcs || ALU_operation !== e.alu ||
                    mem_fault !== e.flt || (MemRead & MemWrite) !== 1'b0) begin
                    errors++;
                    $display("FAIL %s @%0t: got st=%0d strb=%b rd=%b m2r=%b pcs=%b alu=%b flt=%b, want st=%0d strb=%b rd=%b m2r=%b pcs=%b alu=%b flt=%b",
                             e.tag, $time, state_out, a_strb, RegDst, MemtoReg, PCSource,
                             ALU_operation, mem_fault, e.st, e.strb, e.rd, e.m2r, e.pcs,
                             e.alu, e.flt);
                end
            end
        end
    end

    initial begin : stimulus
        // add: IF, ID, REXE, RWB, IF
        do_reset();
        fetch_decode(I_ADD, 1'b0);
        cyc(1'b0, 1'b1, I_ADD, 1'b0, E("add_rexe", 5'd6, 5'b00000, 2'b00, 2'b00, 2'b00, 3'b010, 1'b0));
        cyc(1'b0, 1'b1, I_ADD, 1'b0, E("add_rwb", 5'd7, 5'b00100, 2'b01, 2'b00, 2'b00, 3'b000, 1'b0));
        fetch_next(I_ADD);

        // slt exercises the funct decode
        do_reset();
        fetch_decode(I_SLT, 1'b0);
        cyc(1'b0, 1'b1, I_SLT, 1'b0, E("slt_rexe", 5'd6, 5'b00000, 2'b00, 2'b00, 2'b00, 3'b111, 1'b0));
        cyc(1'b0, 1'b1, I_SLT, 1'b0, E("slt_rwb", 5'd7, 5'b00100, 2'b01, 2'b00, 2'b00, 3'b000, 1'b0));

        // lw with three not-ready cycles in MRD
        do_reset();
        fetch_decode(I_LW, 1'b0);
        cyc(1'b0, 1'b0, I_LW, 1'b0, E("lw_madr", 5'd2, 5'b00000, 2'b00, 2'b00, 2'b00, 3'b010, 1'b0));
        for (int i = 0; i < 3; i++)
            cyc(1'b0, 1'b0, I_LW, 1'b0, E("lw_mrd_wait", 5'd3, 5'b10000, 2'b00, 2'b00, 2'b00, 3'b000, 1'b0));
        cyc(1'b0, 1'b1, I_LW, 1'b0, E("lw_mrd_ready", 5'd3, 5'b10000, 2'b00, 2'b00, 2'b00, 3'b000, 1'b0));
        cyc(1'b0, 1'b1, I_LW, 1'b0, E("lw_lwb", 5'd4, 5'b00100, 2'b00, 2'b01, 2'b00, 3'b000, 1'b0));
        fetch_next(I_LW);

        // fetch never completes: timeout after 4 cycles, HALT is absorbing
        do_reset();
        for (int i = 0; i < 4; i++)
            cyc(1'b0, 1'b0, I_ADD, 1'b0, E("if_wait", 5'd0, 5'b10000, 2'b00, 2'b00, 2'b00, 3'b010, 1'b0));
        for (int i = 0; i < 3; i++)
            cyc(1'b0, 1'b1, I_ADD, 1'b0, E("halt_fault", 5'd15, 5'b00000, 2'b00, 2'b00, 2'b00, 3'b000, 1'b1));

        // ori exercises the opcode decode
        do_reset();
        fetch_decode(I_ORI, 1'b0);
        cyc(1'b0, 1'b1, I_ORI, 1'b0, E("ori_iexe", 5'd10, 5'b00000, 2'b00, 2'b00, 2'b00, 3'b001, 1'b0));
        cyc(1'b0, 1'b1, I_ORI, 1'b0, E("ori_iwb", 5'd11, 5'b00100, 2'b00, 2'b00, 2'b00, 3'b000, 1'b0));

        // lui writes back through MemtoReg=11
        do_reset();
        fetch_decode(I_LUI, 1'b0);
        cyc(1'b0, 1'b1, I_LUI, 1'b0, E("lui_iexe", 5'd10, 5'b00000, 2'b00, 2'b00, 2'b00, 3'b010, 1'b0));
        cyc(1'b0, 1'b1, I_LUI, 1'b0, E("lui_iwb", 5'd11, 5'b00100, 2'b00, 2'b11, 2'b00, 3'b000, 1'b0));

        // addi with overflow
        do_reset();
        fetch_decode(I_ADDI, 1'b1);
        cyc(1'b0, 1'b1, I_ADDI, 1'b1, E("addi_iexe", 5'd10, 5'b00000, 2'b00, 2'b00, 2'b00, 3'b010, 1'b0));
`ifdef MC_CTRL_EXC_EN
        cyc(1'b0, 1'b1, I_ADDI, 1'b1, E("addi_ovf_exc", 5'd14, 5'b00010, 2'b00, 2'b00, 2'b11, 3'b000, 1'b0));
`else
        cyc(1'b0, 1'b1, I_ADDI, 1'b1, E("addi_ovf_iwb", 5'd11, 5'b00100, 2'b00, 2'b00, 2'b00, 3'b000, 1'b0));
`endif
        fetch_next(I_ADDI);

        // jal
        do_reset();
        fetch_decode(I_JAL, 1'b0);
        cyc(1'b0, 1'b1, I_JAL, 1'b0, E("jal", 5'd12, 5'b00110, 2'b10, 2'b10, 2'b10, 3'b000, 1'b0));
        fetch_next(I_JAL);

        // beq
        do_reset();
        fetch_decode(I_BEQ, 1'b0);
        cyc(1'b0, 1'b1, I_BEQ, 1'b0, E("beq_br", 5'd8, 5'b00000, 2'b00, 2'b00, 2'b01, 3'b110, 1'b0));
        fetch_next(I_BEQ);

        // illegal opcode
        do_reset();
        fetch_decode(I_BAD, 1'b0);
`ifdef MC_CTRL_EXC_EN
        cyc(1'b0, 1'b1, I_BAD, 1'b0, E("illegal_exc", 5'd14, 5'b00010, 2'b00, 2'b00, 2'b11, 3'b000, 1'b0));
        fetch_next(I_BAD);
`else
        cyc(1'b0, 1'b1, I_BAD, 1'b0, E("illegal_halt", 5'd15, 5'b00000, 2'b00, 2'b00, 2'b00, 3'b000, 1'b0));
        cyc(1'b0, 1'b1, I_BAD, 1'b0, E("illegal_halt", 5'd15, 5'b00000, 2'b00, 2'b00, 2'b00, 3'b000, 1'b0));
`endif

        // sw stalled in MWR, then reset asserted mid-cycle
        do_reset();
        fetch_decode(I_SW, 1'b0);
        cyc(1'b0, 1'b0, I_SW, 1'b0, E("sw_madr", 5'd2, 5'b00000, 2'b00, 2'b00, 2'b00, 3'b010, 1'b0));
        cyc(1'b0, 1'b0, I_SW, 1'b0, E("sw_mwr", 5'd5, 5'b01000, 2'b00, 2'b00, 2'b00, 3'b000, 1'b0));
        cyc(1'b0, 1'b0, I_SW, 1'b0, E("sw_mwr", 5'd5, 5'b01000, 2'b00, 2'b00, 2'b00, 3'b000, 1'b0));
        cyc(1'b1, 1'b0, I_SW, 1'b0, E("sw_async_reset", 5'd0, 5'b00000, 2'b00, 2'b00, 2'b00, 3'b000, 1'b0));
        cyc(1'b0, 1'b0, I_SW, 1'b0, E("post_abort", 5'd0, 5'b00000, 2'b00, 2'b00, 2'b00, 3'b000, 1'b0));
        fetch_next(I_SW);

        @(negedge clk);
        #1;
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: %0d entries left, want 0", sb.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
